// File: rtl/jtag_dtm.sv
// jtag_dtm: IEEE 1149.1 TAP with a RISC-V style debug transport (IDCODE, DTMCS, DMIACCESS, BYPASS).
// Optional feature macro: JTAG_DTM_HARDRESET_EN (DTMCS bit17 aborts the outstanding DMI request).
// Ports:
//   tck, trst_n                 JTAG clock and asynchronous active-low reset
//   tms, tdi                    sampled on rising tck
//   tdo, tdo_oe                 serial out (falling tck), high-Z enable during Shift-IR/DR
//   dmi_req_*                   DMI request: valid/ready, addr[ABITS], op[2] (1=read, 2=write), data[32]
//   dmi_resp_*                  DMI response: valid/ready, data[32], op[2] (0=ok, 2=failed, 3=busy)
module jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h00000001,
  parameter int          ABITS  = 7
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_oe,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [1:0]       dmi_req_op,
  output logic [31:0]      dmi_req_data,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_op
);
  localparam int W = ABITS + 34;
  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
                         SHDR = 4'h2, EX1DR = 4'h1, PAUSEDR = 4'h3, EX2DR = 4'h0,
                         UPDDR = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR = 4'hA,
                         EX1IR = 4'h9, PAUSEIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;
  localparam logic [4:0] IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11;
  localparam logic [5:0] ABITS6 = 6'(ABITS);

  logic [3:0]       state_q, state_d;
  logic [4:0]       ir_q, ir_d, irsr_q, irsr_d;
  logic [W-1:0]     dr_q, dr_d;
  logic [1:0]       dmistat_q, dmistat_d, req_op_q, req_op_d;
  logic             busy_q, busy_d, req_valid_q, req_valid_d, tdo_q;
  logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic [31:0]      req_data_q, req_data_d, last_data_q, last_data_d;
  logic             is_idcode, is_dtmcs, is_dmi;
  logic [1:0]       cap_op;
  logic [31:0]      dtmcs_cap;

  assign is_idcode = ir_q == IR_IDCODE;
  assign is_dtmcs  = ir_q == IR_DTMCS;
  assign is_dmi    = ir_q == IR_DMI;
  assign cap_op    = dmistat_q != 2'd0 ? dmistat_q : busy_q ? 2'd3 : 2'd0;
  assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, ABITS6, 4'd1};

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms ? TLR   : RTI;
      RTI:     state_d = tms ? SELDR : RTI;
      SELDR:   state_d = tms ? SELIR : CAPDR;
      CAPDR:   state_d = tms ? EX1DR : SHDR;
      SHDR:    state_d = tms ? EX1DR : SHDR;
      EX1DR:   state_d = tms ? UPDDR : PAUSEDR;
      PAUSEDR: state_d = tms ? EX2DR : PAUSEDR;
      EX2DR:   state_d = tms ? UPDDR : SHDR;
      UPDDR:   state_d = tms ? SELDR : RTI;
      SELIR:   state_d = tms ? TLR   : CAPIR;
      CAPIR:   state_d = tms ? EX1IR : SHIR;
      SHIR:    state_d = tms ? EX1IR : SHIR;
      EX1IR:   state_d = tms ? UPDIR : PAUSEIR;
      PAUSEIR: state_d = tms ? EX2IR : PAUSEIR;
      EX2IR:   state_d = tms ? UPDIR : SHIR;
      UPDIR:   state_d = tms ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    irsr_d      = state_q == CAPIR ? 5'b00001 : state_q == SHIR ? {tdi, irsr_q[4:1]} : irsr_q;
    ir_d        = state_q == TLR ? IR_IDCODE : state_q == UPDIR ? irsr_q : ir_q;
    dr_d        = dr_q;
    dmistat_d   = dmistat_q;
    busy_d      = busy_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (state_q == CAPDR)
      dr_d = is_dmi ? {last_addr_q, last_data_q, cap_op} : is_dtmcs ? W'(dtmcs_cap) : is_idcode ? W'(IDCODE) : '0;
    // 32-bit registers insert tdi at bit 31 so the unused upper bits stay zero
    if (state_q == SHDR)
      dr_d = is_dmi ? {tdi, dr_q[W-1:1]} : (is_dtmcs || is_idcode) ? W'({tdi, dr_q[31:1]}) : W'(tdi);
    if (req_valid_q && dmi_req_ready)
      req_valid_d = 1'b0;
    if (dmi_resp_valid && busy_q) begin
      last_data_d = dmi_resp_data;
      busy_d      = 1'b0;
      if (dmi_resp_op == 2'd2 && dmistat_q == 2'd0)
        dmistat_d = 2'd2;
    end
    if (state_q == UPDDR && is_dtmcs) begin
      if (dr_q[16])
        dmistat_d = 2'd0;
`ifdef JTAG_DTM_HARDRESET_EN
      if (dr_q[17]) begin
        req_valid_d = 1'b0;
        busy_d      = 1'b0;
        dmistat_d   = 2'd0;
      end
`endif
    end
    // busy_q (not busy_d) keeps a request from completing and reissuing in one cycle
    if (state_q == UPDDR && is_dmi) begin
      if (busy_q)
        dmistat_d = 2'd3;
      else if (dmistat_q == 2'd0 && (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
        req_valid_d = 1'b1;
        busy_d      = 1'b1;
        req_addr_d  = dr_q[W-1:34];
        req_data_d  = dr_q[33:2];
        req_op_d    = dr_q[1:0];
        last_addr_d = dr_q[W-1:34];
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= TLR;
      ir_q        <= IR_IDCODE;
      irsr_q      <= '0;
      dr_q        <= '0;
      dmistat_q   <= '0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      irsr_q      <= irsr_d;
      dr_q        <= dr_d;
      dmistat_q   <= dmistat_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n)
      tdo_q <= 1'b0;
    else
      tdo_q <= state_q == SHIR ? irsr_q[0] : state_q == SHDR ? dr_q[0] : 1'b0;
  end

  assign tdo            = tdo_q;
  assign tdo_oe         = state_q == SHIR || state_q == SHDR;
  assign dmi_req_valid  = req_valid_q;
  assign dmi_req_addr   = req_addr_q;
  assign dmi_req_data   = req_data_q;
  assign dmi_req_op     = req_op_q;
  assign dmi_resp_ready = busy_q;
endmodule
